// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
package ctrl_pkg;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       sign_zero;
    logic [1:0] alu_op;
    logic       valid;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/ctrl_pipe_fwd_sel.sv
// Operand forwarding select: picks MEM over WB, falls back to the register file.
module fwd_sel
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_REG;
    if (mem_regwrite && (mem_dest != '0) && (mem_dest == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_dest != '0) && (wb_dest == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use stall, branch/jump flush and forwarding.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              branch_taken,
  output logic [11:0]       ex_ctrl,
  output logic              mem_regwrite,
  output logic              mem_memtoreg,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] mem_dest,
  output logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              if_flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t             id_c;
  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              mem_regwrite_q, mem_regwrite_d;
  logic              mem_memtoreg_q, mem_memtoreg_d;
  logic              mem_memread_q, mem_memread_d;
  logic              mem_memwrite_q, mem_memwrite_d;
  logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              wb_memtoreg_q, wb_memtoreg_d;
  logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              load_use;
  logic              stall;

  assign id_c = ctrl_t'(id_ctrl);

  assign load_use = ex_ctrl_q.mem_read && (ex_rt_q != '0) &&
                    ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));

  // A taken branch squashes the ID instruction anyway, so it wins over the stall.
  assign stall      = load_use && !branch_taken;
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign if_flush   = branch_taken || (id_c.jump && !load_use);

  always_comb begin
    ex_ctrl_d = id_c;
    ex_rs_d   = id_rs;
    ex_rt_d   = id_rt;
    ex_dest_d = id_c.reg_dst ? id_rd : id_rt;
    if (branch_taken || load_use) begin
      ex_ctrl_d = CTRL_BUBBLE;
      ex_rs_d   = '0;
      ex_rt_d   = '0;
      ex_dest_d = '0;
    end

    mem_regwrite_d = ex_ctrl_q.reg_write;
    mem_memtoreg_d = ex_ctrl_q.mem_to_reg;
    mem_memread_d  = ex_ctrl_q.mem_read;
    mem_memwrite_d = ex_ctrl_q.mem_write;
    mem_dest_d     = ex_dest_q;

    wb_regwrite_d = mem_regwrite_q;
    wb_memtoreg_d = mem_memtoreg_q;
    wb_dest_d     = mem_dest_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q      <= CTRL_BUBBLE;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dest_q      <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_dest_q     <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_dest_q      <= '0;
      stall_cnt_q    <= '0;
    end else begin
      ex_ctrl_q      <= ex_ctrl_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dest_q      <= ex_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memtoreg_q <= mem_memtoreg_d;
      mem_memread_q  <= mem_memread_d;
      mem_memwrite_q <= mem_memwrite_d;
      mem_dest_q     <= mem_dest_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_memtoreg_q  <= wb_memtoreg_d;
      wb_dest_q      <= wb_dest_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src          (ex_rs_q),
    .mem_regwrite (mem_regwrite_q),
    .mem_dest     (mem_dest_q),
    .wb_regwrite  (wb_regwrite_q),
    .wb_dest      (wb_dest_q),
    .sel          (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src          (ex_rt_q),
    .mem_regwrite (mem_regwrite_q),
    .mem_dest     (mem_dest_q),
    .wb_regwrite  (wb_regwrite_q),
    .wb_dest      (wb_dest_q),
    .sel          (fwd_b)
  );

  assign ex_ctrl      = ex_ctrl_q;
  assign mem_regwrite = mem_regwrite_q;
  assign mem_memtoreg = mem_memtoreg_q;
  assign mem_memread  = mem_memread_q;
  assign mem_memwrite = mem_memwrite_q;
  assign mem_dest     = mem_dest_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_dest      = wb_dest_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: pipeline-of-records model, per-cycle compare, directed and random stimulus.
module tb_ctrl_pipe;

  localparam logic [11:0] C_LW  = 12'h781; // ALUSrc MemtoReg RegWrite MemRead valid
  localparam logic [11:0] C_ADD = 12'h905; // RegDst RegWrite ALUOp=10 valid
  localparam logic [11:0] C_J   = 12'h011; // Jump valid

  logic        clk;
  logic        rst_n;
  logic [11:0] id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        branch_taken;

  logic [11:0] ex_ctrl;
  logic        mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite;
  logic        wb_regwrite, wb_memtoreg;
  logic [4:0]  mem_dest, wb_dest;
  logic [1:0]  fwd_a, fwd_b;
  logic        pc_write, ifid_write, if_flush;
  logic [15:0] stall_cnt;

  // Narrow-counter copy so saturation is reachable in a short run.
  logic [11:0] s_ex_ctrl;
  logic        s_mem_regwrite, s_mem_memtoreg, s_mem_memread, s_mem_memwrite;
  logic        s_wb_regwrite, s_wb_memtoreg;
  logic [4:0]  s_mem_dest, s_wb_dest;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_pc_write, s_ifid_write, s_if_flush;
  logic [3:0]  s_stall_cnt;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .branch_taken(branch_taken), .ex_ctrl(ex_ctrl),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .mem_dest(mem_dest), .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush), .stall_cnt(stall_cnt)
  );

  ctrl_pipe #(.REG_AW(5), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .branch_taken(branch_taken), .ex_ctrl(s_ex_ctrl),
    .mem_regwrite(s_mem_regwrite), .mem_memtoreg(s_mem_memtoreg), .mem_memread(s_mem_memread),
    .mem_memwrite(s_mem_memwrite), .wb_regwrite(s_wb_regwrite), .wb_memtoreg(s_wb_memtoreg),
    .mem_dest(s_mem_dest), .wb_dest(s_wb_dest), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .if_flush(s_if_flush),
    .stall_cnt(s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one record per in-flight instruction slot.
  typedef struct packed {
    logic [11:0] c;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
  } rec_t;

  rec_t m_ex, m_mem, m_wb;
  int   m_cnt;

  function automatic logic m_hazard();
    return m_ex.c[7] && (m_ex.rt != 0) && ((m_ex.rt == id_rs) || (m_ex.rt == id_rt));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (m_mem.c[8] && (m_mem.dst != 0) && (m_mem.dst == src)) return 2'b10;
    if (m_wb.c[8] && (m_wb.dst != 0) && (m_wb.dst == src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic rec_t m_from_id();
    rec_t r;
    r.c   = id_ctrl;
    r.rs  = id_rs;
    r.rt  = id_rt;
    r.dst = id_ctrl[11] ? id_rd : id_rt;
    return r;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  <= '0;
      m_mem <= '0;
      m_wb  <= '0;
      m_cnt <= 0;
    end else begin
      m_wb  <= m_mem;
      m_mem <= m_ex;
      m_ex  <= (m_hazard() || branch_taken) ? rec_t'('0) : m_from_id();
      if (m_hazard() && !branch_taken) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ex.c));
    chk("mem_regwrite", 32'(mem_regwrite), 32'(m_mem.c[8]));
    chk("mem_memtoreg", 32'(mem_memtoreg), 32'(m_mem.c[9]));
    chk("mem_memread", 32'(mem_memread), 32'(m_mem.c[7]));
    chk("mem_memwrite", 32'(mem_memwrite), 32'(m_mem.c[6]));
    chk("mem_dest", 32'(mem_dest), 32'(m_mem.dst));
    chk("wb_regwrite", 32'(wb_regwrite), 32'(m_wb.c[8]));
    chk("wb_memtoreg", 32'(wb_memtoreg), 32'(m_wb.c[9]));
    chk("wb_dest", 32'(wb_dest), 32'(m_wb.dst));
    chk("fwd_a", 32'(fwd_a), 32'(m_fwd(m_ex.rs)));
    chk("fwd_b", 32'(fwd_b), 32'(m_fwd(m_ex.rt)));
    chk("pc_write", 32'(pc_write), 32'(!(m_hazard() && !branch_taken)));
    chk("ifid_write", 32'(ifid_write), 32'(!(m_hazard() && !branch_taken)));
    chk("if_flush", 32'(if_flush), 32'(branch_taken || (id_ctrl[4] && !m_hazard())));
    chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_cnt, 65535)));
    chk("stall_cnt_w4", 32'(s_stall_cnt), 32'(sat(m_cnt, 15)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    id_ctrl = c;
    id_rs   = rs;
    id_rt   = rt;
    id_rd   = rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    branch_taken = 1'b0;
    set_id(12'h000, 5'd0, 5'd0, 5'd0);
    step();
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_mem_dest", 32'(mem_dest), 32'h0);
    chk("rst_wb_dest", 32'(wb_dest), 32'h0);
    chk("rst_pc_write", 32'(pc_write), 32'h1);
    chk("rst_ifid_write", 32'(ifid_write), 32'h1);
    chk("rst_if_flush", 32'(if_flush), 32'h0);
    chk("rst_fwd_a", 32'(fwd_a), 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0;
    set_id(12'h000, 5'd0, 5'd0, 5'd0);
    do_reset();

    // lw $t0 in EX, dependent add in ID
    set_id(C_LW, 5'd0, 5'd8, 5'd0);
    step();
    set_id(C_ADD, 5'd8, 5'd9, 5'd10);
    #1;
    chk("lu_pc_write", 32'(pc_write), 32'h0);
    chk("lu_ifid_write", 32'(ifid_write), 32'h0);
    chk("lu_cnt_before", 32'(stall_cnt), 32'h0);
    step();
    chk("lu_ex_bubble", 32'(ex_ctrl), 32'h0);
    chk("lu_cnt_after", 32'(stall_cnt), 32'h1);
    chk("lu_mem_memread", 32'(mem_memread), 32'h1);
    chk("lu_mem_dest", 32'(mem_dest), 32'd8);
    chk("lu_pc_resume", 32'(pc_write), 32'h1);
    step();
    chk("lu_ex_add", 32'(ex_ctrl), 32'(C_ADD));
    chk("lu_fwd_a_wb", 32'(fwd_a), 32'b01);
    chk("lu_wb_dest", 32'(wb_dest), 32'd8);

    // MEM-over-WB priority, then WB-only when MEM dest is $zero
    set_id(C_ADD, 5'd1, 5'd2, 5'd5); step();
    set_id(C_ADD, 5'd1, 5'd2, 5'd5); step();
    set_id(C_ADD, 5'd5, 5'd0, 5'd6); step();
    chk("prio_fwd_a_mem", 32'(fwd_a), 32'b10);
    chk("prio_fwd_b_reg", 32'(fwd_b), 32'b00);
    set_id(C_ADD, 5'd1, 5'd2, 5'd5); step();
    set_id(C_ADD, 5'd1, 5'd2, 5'd0); step();
    set_id(C_ADD, 5'd5, 5'd0, 5'd6); step();
    chk("zero_fwd_a_wb", 32'(fwd_a), 32'b01);

    // Load-use plus branch taken
    do_reset();
    set_id(C_LW, 5'd0, 5'd8, 5'd0);
    step();
    set_id(C_ADD, 5'd8, 5'd9, 5'd10);
    branch_taken = 1'b1;
    #1;
    chk("br_if_flush", 32'(if_flush), 32'h1);
    chk("br_pc_write", 32'(pc_write), 32'h1);
    chk("br_ifid_write", 32'(ifid_write), 32'h1);
    step();
    branch_taken = 1'b0;
    chk("br_ex_bubble", 32'(ex_ctrl), 32'h0);
    chk("br_cnt", 32'(stall_cnt), 32'h0);

    // Jump, then jump held behind a load-use stall
    do_reset();
    set_id(C_J, 5'd0, 5'd0, 5'd0);
    #1;
    chk("j_if_flush", 32'(if_flush), 32'h1);
    step();
    set_id(12'h000, 5'd0, 5'd0, 5'd0);
    #1;
    chk("j_ex_jump", 32'(ex_ctrl[4]), 32'h1);
    chk("j_flush_once", 32'(if_flush), 32'h0);
    set_id(C_LW, 5'd0, 5'd8, 5'd0);
    step();
    set_id(C_J, 5'd8, 5'd0, 5'd0);
    #1;
    chk("jd_flush_held", 32'(if_flush), 32'h0);
    chk("jd_pc_write", 32'(pc_write), 32'h0);
    step();
    chk("jd_flush_late", 32'(if_flush), 32'h1);
    chk("jd_pc_resume", 32'(pc_write), 32'h1);
    step();
    chk("jd_ex_jump", 32'(ex_ctrl), 32'(C_J));

    // Saturation: 19 stalls; the 4-bit counter pins at all-ones
    do_reset();
    set_id(C_LW, 5'd8, 5'd8, 5'd0);
    repeat (38) step();
    chk("sat_cnt16", 32'(stall_cnt), 32'd19);
    chk("sat_cnt4", 32'(s_stall_cnt), 32'hF);

    // Reset dropped in the middle of a stall
    do_reset();
    set_id(C_LW, 5'd0, 5'd8, 5'd0);
    step();
    set_id(C_ADD, 5'd8, 5'd9, 5'd10);
    step();
    set_id(C_LW, 5'd0, 5'd8, 5'd0);
    step();
    set_id(C_ADD, 5'd8, 5'd9, 5'd10);
    #1;
    chk("mr_pc_write_stall", 32'(pc_write), 32'h0);
    chk("mr_cnt_before", 32'(stall_cnt), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("mr_mem_memread", 32'(mem_memread), 32'h0);
    chk("mr_mem_dest", 32'(mem_dest), 32'h0);
    chk("mr_cnt", 32'(stall_cnt), 32'h0);
    chk("mr_pc_write", 32'(pc_write), 32'h1);
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_pc_release", 32'(pc_write), 32'h1);
    step();
    chk("mr_first_load", 32'(ex_ctrl), 32'(C_ADD));

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        branch_taken = 1'b0;
        set_id(12'h000, 5'd0, 5'd0, 5'd0);
      end else begin
        set_id(12'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)));
        if ($urandom_range(0, 2) == 0) id_ctrl[7] = 1'b1;
        branch_taken = ($urandom_range(0, 7) == 0);
      end
    end
    rst_n = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter: REG_AW, 5, register-specifier width.
REQ-002 Parameter: CNT_W, 16, stall performance-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_ctrl  input  12  decoded ID-stage bundle {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, SignZero, ALUOp[1:0], valid}.
REQ-006 id_rs, id_rt, id_rd  input  REG_AW each  ID-stage register specifiers.
REQ-007 branch_taken  input  1  EX-stage branch resolved taken.
REQ-008 ex_ctrl  output  12  EX-stage control bundle.
REQ-009 mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite  output  1 each  MEM-stage control.
REQ-010 wb_regwrite, wb_memtoreg  output  1 each  WB-stage control.
REQ-011 mem_dest, wb_dest  output  REG_AW each  destination register in MEM and WB.
REQ-012 fwd_a, fwd_b  output  2  ALU operand forwarding selects: 00 regfile, 10 from MEM, 01 from WB.
REQ-013 pc_write, ifid_write  output  1 each  low = hold PC / IF-ID register.
REQ-014 if_flush  output  1  high = load bubble into IF-ID register.
REQ-015 stall_cnt  output  CNT_W  count of load-use stall cycles.

Function
REQ-016 EX stage SHALL capture id_ctrl, id_rs, id_rt, id_rd each edge; MEM stage SHALL capture EX values; WB stage SHALL capture MEM values (one cycle per stage).
REQ-017 EX destination SHALL be id_rd when RegDst=1, else id_rt; it SHALL propagate unchanged to mem_dest, then wb_dest.
REQ-018 load-use hazard SHALL be ex_ctrl.MemRead & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt), evaluated combinationally.
REQ-019 On hazard (and no branch_taken): pc_write=0, ifid_write=0, all-zero bubble loaded into EX next edge; MEM/WB advance normally.
REQ-020 branch_taken SHALL force if_flush=1 and an all-zero bubble into EX next edge, overriding any hazard; pc_write=ifid_write=1.
REQ-021 id_ctrl.Jump & ~hazard SHALL assert if_flush; the jump itself proceeds into EX; under hazard the jump flush is deferred until the stall clears.
REQ-022 fwd_a SHALL be 10 when mem_regwrite & mem_dest!=0 & mem_dest==ex_rs; else 01 when wb_regwrite & wb_dest!=0 & wb_dest==ex_rs; else 00; fwd_b identical against ex_rt.
REQ-023 MEM forwarding SHALL have priority over WB when both match.
REQ-024 stall_cnt SHALL increment by 1 each cycle REQ-019 applies, saturating at all-ones (no wrap).
REQ-025 Bubble SHALL carry valid=0 and all control bits 0; specifiers zeroed.
REQ-026 Outputs other than fwd_*, pc_write, ifid_write, if_flush SHALL be registered.

Reset
REQ-027 While rst_n=0: all stage registers, mem_dest, wb_dest, stall_cnt = 0; ex_ctrl = bubble.
REQ-028 During reset pc_write=ifid_write=1, if_flush=0, fwd_a=fwd_b=00 (derive from zeroed state).
REQ-029 Reset asserted mid-stall or mid-flush SHALL discard all in-flight control immediately; first post-reset edge loads id_ctrl normally.

Structure
REQ-030 Shared package ctrl_pkg SHALL hold the control-bundle typedef, bubble constant, ALUOp encodings, FWD_REG/FWD_MEM/FWD_WB constants.
REQ-031 One sub-module fwd_sel (combinational compare/priority) SHALL be instantiated twice, for operands A and B.

Verification
REQ-032 lw $t0 (MemRead=1, rt=8) in EX, ID add rs=8 -> pc_write=0, ifid_write=0, next EX bubble, stall_cnt 0->1.
REQ-033 Same as REQ-032 plus branch_taken=1 -> if_flush=1, pc_write=1, EX bubble, stall_cnt unchanged.
REQ-034 MEM dest=5 RegWrite=1, WB dest=5 RegWrite=1, ex_rs=5 -> fwd_a=10; MEM dest=0 instead -> fwd_a=01.
REQ-035 ID j (Jump=1), no hazard -> if_flush=1 one cycle; ex_ctrl.Jump=1 next cycle.
REQ-036 Force 2^CNT_W+3 stall cycles -> stall_cnt holds 16'hFFFF.
REQ-037 rst_n low for 1 cycle mid-stall -> all registered outputs 0 immediately, pc_write=1 after release.
